div_seq: RTL and testbench

Iterative 32-bit integer divider with its own sequencing FSM for the MIPS pipeline's execute stage. It serves DIV/DIVU: it captures operands when the decoded divide reaches execute and stalls the pipeline while iterating. It returns quotient (LO) and remainder (HI) for one cycle, and aborts cleanly when the execute stage is flushed.

---
 rtl/div_seq.sv | 147 ++++++++++++++
 tb/tb_div_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Iterative restoring 32-bit divider (DIV/DIVU) with its own IDLE/BUSY/DONE sequencer.
// Optional early-out path for b==0 or |a|<|b| is enabled by defining DIV_BYPASS_EN.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic             signedE,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sign_quo_q, sign_quo_d;
    logic             sign_rem_q, sign_rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] remd_q, remd_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic             start_go, last_step, bypass;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] step_rem, step_dvd, fix_q, fix_r;

    always_comb begin
        a_mag     = (signedE & a[WIDTH-1]) ? -a : a;
        b_mag     = (signedE & b[WIDTH-1]) ? -b : b;
        start_go  = (state_q == IDLE) & startE & ~cancel;
        last_step = (cnt_q == CW'(WIDTH - 1));
`ifdef DIV_BYPASS_EN
        bypass    = (b == '0) | (a_mag < b_mag);
`else
        bypass    = 1'b0;
`endif
        // One restoring step: shift {rem, dividend} left, try subtracting the divisor.
        rem_sh    = {rem_q, dvd_q[WIDTH-1]};
        trial     = rem_sh - {1'b0, dvs_q};
        step_rem  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        step_dvd  = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
        fix_q     = sign_quo_q ? -step_dvd : step_dvd;
        fix_r     = sign_rem_q ? -step_rem : step_rem;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_go) state_d = bypass ? DONE : BUSY;
            BUSY:    if (last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (cancel) state_d = IDLE;
    end

    // Handshake: startE is held until stall drops; valid marks the single DONE cycle
    // in which quotient/remainder are written to LO/HI. cancel suppresses both.
    always_comb begin
        stall     = rst & startE & (state_q != DONE) & ~cancel;
        valid     = (state_q == DONE) & ~cancel;
        busy      = (state_q != IDLE);
        state_dbg = state_q;
        quotient  = quo_q;
        remainder = remd_q;
    end

    always_comb begin
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        sign_quo_d = sign_quo_q;
        sign_rem_d = sign_rem_q;
        quo_d      = quo_q;
        remd_d     = remd_q;
        if (start_go) begin
            cnt_d      = '0;
            rem_d      = '0;
            dvd_d      = a_mag;
            dvs_d      = b_mag;
            sign_quo_d = signedE & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_rem_d = signedE & a[WIDTH-1];
            if (bypass) begin
                quo_d  = (b == '0) ? '1 : '0;
                remd_d = a;
            end
        end else if ((state_q == BUSY) && !cancel) begin
            rem_d = step_rem;
            dvd_d = step_dvd;
            cnt_d = cnt_q + CW'(1);
            // Result registers load on the last step so they are ready in DONE.
            if (last_step) begin
                quo_d  = fix_q;
                remd_d = fix_r;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            quo_q      <= '0;
            remd_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            sign_quo_q <= sign_quo_d;
            sign_rem_q <= sign_rem_d;
            quo_q      <= quo_d;
            remd_q     <= remd_d;
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: latency, signed/unsigned results,
// divide by zero, overflow, cancel, back-to-back issue and mid-operation reset.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        startE;
    logic        signedE;
    logic        cancel;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic        busy;
    logic        valid;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [1:0]  state_dbg;

    int passed = 0;
    int total  = 0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;

`ifdef DIV_BYPASS_EN
    localparam int LAT_BYP = 1;
`else
    localparam int LAT_BYP = 33;
`endif

    div_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .startE    (startE),
        .signedE   (signedE),
        .cancel    (cancel),
        .a         (a),
        .b         (b),
        .stall     (stall),
        .busy      (busy),
        .valid     (valid),
        .quotient  (quotient),
        .remainder (remainder),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Issue one divide at a negedge and follow it until valid (bounded).
    task automatic run_div(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                           input logic sg, input logic [31:0] eq, input logic [31:0] er,
                           input int lat_exp);
        int lat;
        logic stall_ok;
        @(negedge clk);
        a = aa; b = bb; signedE = sg; startE = 1'b1;
        #1;
        chk({tag, ".stall_start"}, 32'(stall), 32'd1);
        lat = 0;
        stall_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!valid && !stall) stall_ok = 1'b0;
        end while (!valid && lat < 60);
        chk({tag, ".latency"}, 32'(lat), 32'(lat_exp));
        chk({tag, ".stall_held"}, 32'(stall_ok), 32'd1);
        chk({tag, ".valid"}, 32'(valid), 32'd1);
        chk({tag, ".quotient"}, quotient, eq);
        chk({tag, ".remainder"}, remainder, er);
        chk({tag, ".stall_done"}, 32'(stall), 32'd0);
        last_q = eq;
        last_r = er;
    endtask

    task automatic release_start(input string tag);
        @(negedge clk);
        startE = 1'b0;
        #1;
        chk({tag, ".busy_after"}, 32'(busy), 32'd0);
        chk({tag, ".valid_after"}, 32'(valid), 32'd0);
        chk({tag, ".q_stable"}, quotient, last_q);
        chk({tag, ".r_stable"}, remainder, last_r);
    endtask

    initial begin
        int vcount;
        rst = 1'b1; startE = 1'b1; signedE = 1'b0; cancel = 1'b0; a = '0; b = '0;
        #2 rst = 1'b0;
        #1;
        chk("reset.stall", 32'(stall), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.valid", 32'(valid), 32'd0);
        chk("reset.quotient", quotient, 32'd0);
        chk("reset.remainder", remainder, 32'd0);
        chk("reset.state", 32'(state_dbg), 32'd0);
        repeat (2) @(negedge clk);
        startE = 1'b0;
        rst = 1'b1;

        run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33);
        release_start("divu_100_7");

        run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        release_start("div_m7_2");

        run_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 33);
        release_start("div_ovf");

        // Cancel in the middle of an iteration.
        @(negedge clk);
        a = 32'd1000; b = 32'd3; signedE = 1'b0; startE = 1'b1;
        repeat (10) @(negedge clk);
        chk("cancel.state_busy", 32'(state_dbg), 32'd1);
        cancel = 1'b1;
        startE = 1'b0;
        #1;
        chk("cancel.valid", 32'(valid), 32'd0);
        chk("cancel.stall", 32'(stall), 32'd0);
        @(negedge clk);
        cancel = 1'b0;
        #1;
        chk("cancel.state_idle", 32'(state_dbg), 32'd0);
        chk("cancel.busy", 32'(busy), 32'd0);
        chk("cancel.q_kept", quotient, last_q);
        chk("cancel.r_kept", remainder, last_r);
        vcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) vcount++;
        end
        chk("cancel.no_valid", 32'(vcount), 32'd0);

        run_div("divu_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33);
        release_start("divu_9_3");

        run_div("divu_5_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, LAT_BYP);
        release_start("divu_5_0");

        run_div("divu_3_10", 32'd3, 32'd10, 1'b0, 32'd0, 32'd3, LAT_BYP);
        release_start("divu_3_10");

        // Back-to-back: second divide issued the cycle after DONE.
        run_div("b2b_50_5", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 33);
        run_div("b2b_49_7", 32'd49, 32'd7, 1'b0, 32'd7, 32'd0, 33);
        release_start("b2b_49_7");

        // Reset in the middle of an iteration.
        @(negedge clk);
        a = 32'd77; b = 32'd5; signedE = 1'b0; startE = 1'b1;
        repeat (15) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid.busy", 32'(busy), 32'd0);
        chk("rst_mid.stall", 32'(stall), 32'd0);
        chk("rst_mid.valid", 32'(valid), 32'd0);
        chk("rst_mid.quotient", quotient, 32'd0);
        chk("rst_mid.remainder", remainder, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        startE = 1'b0;
        last_q = '0;
        last_r = '0;

        run_div("divu_123_10", 32'd123, 32'd10, 1'b0, 32'd12, 32'd3, 33);
        release_start("divu_123_10");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
